// File: rtl/tl_tx_credit_mgr.sv
// Transmit-side flow-control credit manager: tracks limits and consumed credits
// for the six posted/non-posted/completion pools and flags TLP admissibility.

module tl_tx_credit_pool #(
    parameter int unsigned W       = 8,
    parameter bit          IS_DATA = 1'b0,
    parameter int unsigned REQ     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         init_i,
    input  logic         upd_i,
    input  logic         active_i,
    input  logic         active_nxt_i,
    input  logic [W-1:0] limit_i,
    input  logic         consume_v_i,
    input  logic [W-1:0] consume_dw_i,
    output logic         ok_o,
    output logic         inf_o
);
    localparam int unsigned WE    = W + 2;
    localparam logic [W-1:0] HALF  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] REQ_W = W'(REQ);

    logic [W-1:0]  cl_q, cl_d, cc_q, cc_d, amt, diff;
    logic [WE-1:0] dw_up;
    logic          inf_q, inf_d, ok_q, ok_d;

    // Next-state limit/consumed values; ok is evaluated against those next values
    always_comb begin
        cl_d  = cl_q;
        cc_d  = cc_q;
        inf_d = inf_q;
        dw_up = WE'(consume_dw_i) + WE'(3);
        amt   = IS_DATA ? W'(dw_up >> 2) : consume_dw_i;
        if (clr_i) begin
            cl_d  = '0;
            cc_d  = '0;
            inf_d = 1'b0;
        end else begin
            if (init_i) begin
                cl_d  = limit_i;
                inf_d = (limit_i == '0);
            end
            if (upd_i && !inf_q) cl_d = limit_i;
            if (active_i && consume_v_i && !inf_q) cc_d = cc_q + amt;
        end
        diff = cl_d - (cc_d + REQ_W);
        ok_d = active_nxt_i && (inf_d || (diff <= HALF));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cl_q  <= '0;
            cc_q  <= '0;
            inf_q <= 1'b0;
            ok_q  <= 1'b0;
        end else begin
            cl_q  <= cl_d;
            cc_q  <= cc_d;
            inf_q <= inf_d;
            ok_q  <= ok_d;
        end
    end

    assign ok_o  = ok_q;
    assign inf_o = inf_q;
endmodule

module tl_tx_credit_mgr #(
    parameter int unsigned PH_WIDTH      = 8,
    parameter int unsigned PD_WIDTH      = 12,
    parameter int unsigned NPH_WIDTH     = 8,
    parameter int unsigned NPD_WIDTH     = 12,
    parameter int unsigned CPLH_WIDTH    = 8,
    parameter int unsigned CPLD_WIDTH    = 12,
    parameter int unsigned MAX_PD_CRED   = 16,
    parameter int unsigned MAX_NPD_CRED  = 1,
    parameter int unsigned MAX_CPLD_CRED = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  link_up_i,
    input  logic                  fc_v_i,
    input  logic                  fc_init_i,
    input  logic [1:0]            fc_type_i,
    input  logic [7:0]            fc_hdr_i,
    input  logic [11:0]           fc_data_i,
    input  logic                  ph_consume_v_i,
    input  logic [PH_WIDTH-1:0]   ph_consume_dw_i,
    input  logic                  pd_consume_v_i,
    input  logic [PD_WIDTH-1:0]   pd_consume_dw_i,
    input  logic                  nph_consume_v_i,
    input  logic [NPH_WIDTH-1:0]  nph_consume_dw_i,
    input  logic                  npd_consume_v_i,
    input  logic [NPD_WIDTH-1:0]  npd_consume_dw_i,
    input  logic                  cplh_consume_v_i,
    input  logic [CPLH_WIDTH-1:0] cplh_consume_dw_i,
    input  logic                  cpld_consume_v_i,
    input  logic [CPLD_WIDTH-1:0] cpld_consume_dw_i,
    output logic                  ph_credit_ok_o,
    output logic                  pd_credit_ok_o,
    output logic                  nph_credit_ok_o,
    output logic                  npd_credit_ok_o,
    output logic                  cplh_credit_ok_o,
    output logic                  cpld_credit_ok_o,
    output logic                  fc_active_o,
    output logic                  credit_err_o
);
    typedef enum logic [1:0] {FC_IDLE, FC_INIT, FC_ACTIVE} fc_state_e;

    fc_state_e  state_q, state_d;
    logic [2:0] seen_q, seen_d;
    logic       fc_active_q, fc_active_d, err_q, err_d, link_up_q;
    logic       init_hit, upd_hit, active, active_nxt, clr;
    logic [2:0] typ;
    logic [2:0] init_t, upd_t;
    logic [5:0] cons_v, ok_v, inf_v;

    always_comb begin
        state_d    = state_q;
        seen_d     = seen_q;
        typ        = {fc_type_i == 2'd2, fc_type_i == 2'd1, fc_type_i == 2'd0};
        init_hit   = fc_v_i && fc_init_i && (state_q == FC_INIT) && link_up_i;
        upd_hit    = fc_v_i && !fc_init_i && (state_q == FC_ACTIVE) && link_up_i;
        init_t     = init_hit ? typ : 3'b000;
        upd_t      = upd_hit ? typ : 3'b000;
        clr        = !link_up_i;
        case (state_q)
            FC_IDLE: if (link_up_i) state_d = FC_INIT;
            FC_INIT: begin
                seen_d = seen_q | init_t;
                if (&seen_d) state_d = FC_ACTIVE;
            end
            default: ;
        endcase
        if (!link_up_i) begin
            state_d = FC_IDLE;
            seen_d  = '0;
        end
        active      = (state_q == FC_ACTIVE);
        active_nxt  = (state_d == FC_ACTIVE);
        fc_active_d = active_nxt;
        // Overconsume: consume against a blocked finite pool, or any consume outside ACTIVE
        err_d = err_q | (|(cons_v & ~({6{active}} & (inf_v | ok_v))));
        if (link_up_q && !link_up_i) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FC_IDLE;
            seen_q      <= '0;
            fc_active_q <= 1'b0;
            err_q       <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_q      <= seen_d;
            fc_active_q <= fc_active_d;
            err_q       <= err_d;
            link_up_q   <= link_up_i;
        end
    end

    assign cons_v = {ph_consume_v_i, pd_consume_v_i, nph_consume_v_i,
                     npd_consume_v_i, cplh_consume_v_i, cpld_consume_v_i};
    assign ok_v   = {ph_credit_ok_o, pd_credit_ok_o, nph_credit_ok_o,
                     npd_credit_ok_o, cplh_credit_ok_o, cpld_credit_ok_o};

    tl_tx_credit_pool #(.W(PH_WIDTH), .IS_DATA(1'b0), .REQ(1)) u_ph (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .init_i(init_t[0]), .upd_i(upd_t[0]),
        .active_i(active), .active_nxt_i(active_nxt), .limit_i(PH_WIDTH'(fc_hdr_i)),
        .consume_v_i(ph_consume_v_i), .consume_dw_i(ph_consume_dw_i),
        .ok_o(ph_credit_ok_o), .inf_o(inf_v[5]));
    tl_tx_credit_pool #(.W(PD_WIDTH), .IS_DATA(1'b1), .REQ(MAX_PD_CRED)) u_pd (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .init_i(init_t[0]), .upd_i(upd_t[0]),
        .active_i(active), .active_nxt_i(active_nxt), .limit_i(PD_WIDTH'(fc_data_i)),
        .consume_v_i(pd_consume_v_i), .consume_dw_i(pd_consume_dw_i),
        .ok_o(pd_credit_ok_o), .inf_o(inf_v[4]));
    tl_tx_credit_pool #(.W(NPH_WIDTH), .IS_DATA(1'b0), .REQ(1)) u_nph (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .init_i(init_t[1]), .upd_i(upd_t[1]),
        .active_i(active), .active_nxt_i(active_nxt), .limit_i(NPH_WIDTH'(fc_hdr_i)),
        .consume_v_i(nph_consume_v_i), .consume_dw_i(nph_consume_dw_i),
        .ok_o(nph_credit_ok_o), .inf_o(inf_v[3]));
    tl_tx_credit_pool #(.W(NPD_WIDTH), .IS_DATA(1'b1), .REQ(MAX_NPD_CRED)) u_npd (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .init_i(init_t[1]), .upd_i(upd_t[1]),
        .active_i(active), .active_nxt_i(active_nxt), .limit_i(NPD_WIDTH'(fc_data_i)),
        .consume_v_i(npd_consume_v_i), .consume_dw_i(npd_consume_dw_i),
        .ok_o(npd_credit_ok_o), .inf_o(inf_v[2]));
    tl_tx_credit_pool #(.W(CPLH_WIDTH), .IS_DATA(1'b0), .REQ(1)) u_cplh (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .init_i(init_t[2]), .upd_i(upd_t[2]),
        .active_i(active), .active_nxt_i(active_nxt), .limit_i(CPLH_WIDTH'(fc_hdr_i)),
        .consume_v_i(cplh_consume_v_i), .consume_dw_i(cplh_consume_dw_i),
        .ok_o(cplh_credit_ok_o), .inf_o(inf_v[1]));
    tl_tx_credit_pool #(.W(CPLD_WIDTH), .IS_DATA(1'b1), .REQ(MAX_CPLD_CRED)) u_cpld (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .init_i(init_t[2]), .upd_i(upd_t[2]),
        .active_i(active), .active_nxt_i(active_nxt), .limit_i(CPLD_WIDTH'(fc_data_i)),
        .consume_v_i(cpld_consume_v_i), .consume_dw_i(cpld_consume_dw_i),
        .ok_o(cpld_credit_ok_o), .inf_o(inf_v[0]));

    assign fc_active_o  = fc_active_q;
    assign credit_err_o = err_q;
endmodule

// File: doc/tl_tx_credit_mgr.md
TL_TX_CREDIT_MGR -- requirements
Module: tl_tx_credit_mgr

Interface
REQ-001 SHALL have parameters: PH_WIDTH=8, PD_WIDTH=12, NPH_WIDTH=8, NPD_WIDTH=12, CPLH_WIDTH=8, CPLD_WIDTH=12 (credit counter widths); MAX_PD_CRED=16, MAX_NPD_CRED=1, MAX_CPLD_CRED=16 (data credits a worst-case TLP needs).
REQ-002 SHALL have ports clk in 1 (single clock) and rst_n in 1 (asynchronous, active-low reset), listed first.
REQ-003 SHALL have link_up_i in 1: DLL link-up status.
REQ-004 SHALL have fc_v_i in 1: FC DLLP valid pulse.
REQ-005 SHALL have fc_init_i in 1: 1=InitFC, 0=UpdateFC.
REQ-006 SHALL have fc_type_i in 2: 0=P, 1=NP, 2=CPL, 3=reserved.
REQ-007 SHALL have fc_hdr_i in 8 (HdrFC) and fc_data_i in 12 (DataFC).
REQ-008 SHALL have, per pool X in {ph,pd,nph,npd,cplh,cpld}: X_consume_v_i in 1 and X_consume_dw_i in X_WIDTH (header pools: credits; data pools: DW count).
REQ-009 SHALL have X_credit_ok_o out 1 per pool: credits sufficient for the next TLP.
REQ-010 SHALL have fc_active_o out 1 (FC initialised) and credit_err_o out 1 (sticky overconsume error).

Function
REQ-011 SHALL implement FSM FC_IDLE -> FC_INIT -> FC_ACTIVE.
REQ-012 FC_IDLE SHALL go to FC_INIT on link_up_i=1.
REQ-013 FC_INIT SHALL go to FC_ACTIVE one cycle after InitFC has been received for all of P, NP and CPL.
REQ-014 Any state SHALL go to FC_IDLE when link_up_i=0; on that edge all limits, consumed counters, infinite flags and seen flags SHALL clear.
REQ-015 In FC_INIT, InitFC for type T SHALL load CL[TH]<=fc_hdr_i, CL[TD]<=fc_data_i and set the seen[T] flag; a value of 0 SHALL set the pool's infinite flag.
REQ-016 A repeated InitFC for the same type in FC_INIT SHALL overwrite the limits.
REQ-017 UpdateFC SHALL be ignored in FC_INIT.
REQ-018 In FC_ACTIVE, UpdateFC SHALL load CL absolutely (not additively) for non-infinite pools only.
REQ-019 InitFC in FC_ACTIVE SHALL be ignored.
REQ-020 fc_type_i=3 SHALL always be ignored.
REQ-021 Consume, FC_ACTIVE only: header pool CC <= CC + X_consume_dw_i.
REQ-022 Consume, FC_ACTIVE only: data pool CC <= CC + ceil(X_consume_dw_i/4).
REQ-023 All CC/CL arithmetic SHALL be modulo 2^X_WIDTH; wrap-around is legal.
REQ-024 Consumes for infinite pools SHALL be ignored.
REQ-025 A same-cycle UpdateFC and consume on one pool SHALL both apply, with the new CL used against the new CC.
REQ-026 X_credit_ok_o SHALL be registered and computed from next-state CL/CC, so a consume or update in cycle N is reflected at cycle N+1 (1-cycle latency, never stale by 2).
REQ-027 ok rule: (CL - (CC + REQ)) mod 2^W <= 2^(W-1), where REQ=1 for header pools and MAX_*_CRED for data pools.
REQ-028 Infinite pool in FC_ACTIVE SHALL give ok=1; any pool outside FC_ACTIVE SHALL give ok=0.
REQ-029 credit_err_o SHALL set when consume_v arrives for a non-infinite pool whose ok was 0 that cycle, or when any consume_v arrives outside FC_ACTIVE; it SHALL clear only on reset or on the link_up_i falling edge.
REQ-030 fc_active_o SHALL be 1 exactly when state=FC_ACTIVE, registered.

Reset
REQ-031 On rst_n=0 (async), state SHALL be FC_IDLE; all CL/CC/flags SHALL be 0; all X_credit_ok_o, fc_active_o and credit_err_o SHALL be 0.
REQ-032 Release SHALL be synchronous to clk.
REQ-033 Reset mid-operation SHALL discard all credit state with no partial update.

Verification
REQ-034 link_up=1; InitFC P(hdr=4,data=32), NP(2,0), CPL(0,0) -> fc_active_o=1 next cycle; ph/pd/nph ok=1; npd/cplh/cpld ok=1 (infinite).
REQ-035 Then pd_consume 64 DW (16 cred) twice -> pd ok=1 after first, 0 after second (CC=32=CL); UpdateFC P data=48 -> pd ok=1 next cycle.
REQ-036 PH_WIDTH wrap: CL=2, CC=254; consume 2 -> CC=0; ok=1; consume 1 -> CC=1; ok=1 with CL=2; consume 1 more -> ok=0.
REQ-037 Simultaneous ph_consume 1 and UpdateFC P hdr=CL+1 on the same cycle -> ok unchanged (1), no err.
REQ-038 nph_consume while nph ok=0 -> credit_err_o=1 sticky; link_up 1->0 -> all outputs 0, err cleared, state FC_IDLE.
REQ-039 rst_n asserted in FC_ACTIVE mid-consume -> all outputs 0 immediately (async), FC_INIT re-entered after release with link_up=1.
